replay_buffer_ctrl: RTL and testbench
=====================================

Name: replay_buffer_ctrl

Overview:
Owns the on-chip record/replay byte buffer and sequences it under control of the sequencer's record_en / replay_start / replay_en outputs.
- Record mode: captures bytes from the receive stream into iCE40 block RAM.
- Replay mode: plays the captured bytes out on a valid/ready stream toward the transmit side.
- Sits between the sequencer and the UART TX path; the sequencer decides when, this block decides how.

Parameters:
- DATA_W, 8: byte width of stored and replayed data.
- ADDR_W, 8: buffer address width; DEPTH = 2**ADDR_W entries.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- record_en  input  1  level; capture is permitted while high.
- replay_start  input  1  one-cycle pulse; requests a replay pass.
- replay_en  input  1  level; gates issue of new replay beats.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DATA_W  byte to record.
- out_valid  output  1  out_data holds a replay beat.
- out_data  output  DATA_W  replayed byte.
- out_ready  input  1  sink accepts the beat.
- busy  output  1  high when state is not IDLE.
- overflow  output  1  sticky; a byte was dropped because the buffer was full.
- count  output  ADDR_W+1  number of bytes currently recorded.

Behaviour:
- Reset: state=IDLE, out_valid=0, out_data=0, busy=0, overflow=0, count=0, wr_ptr=0, rd_ptr=0. RAM contents are not cleared; they are unreachable while count=0.
- States: IDLE, RECORD, REPLAY.
- IDLE -> RECORD when record_en=1.
  - On entry: count=0, wr_ptr=0, overflow=0.
  - record_en has priority over replay_start in the same cycle.
- RECORD:
  - Each cycle with in_valid=1 and count<DEPTH: mem[wr_ptr]<=in_data, wr_ptr++, count++.
  - in_valid=1 with count==DEPTH: byte dropped, overflow<=1.
  - record_en=0 -> IDLE; count is retained.
  - replay_start is ignored in RECORD.
- IDLE + replay_start=1:
  - count>0: enter REPLAY with rd_ptr=0.
  - count==0: pulse ignored; state stays IDLE and out_valid stays 0.
- REPLAY:
  - RAM read is synchronous with 1-cycle latency. The read is issued when replay_en=1 and the output register is empty or is being accepted this cycle.
  - First out_valid appears 2 cycles after the replay_start cycle (replay_en=1 throughout).
  - Throughput is 1 byte/cycle while out_ready=1 and replay_en=1; the next address is presented in the accept cycle.
  - Standard valid/ready rule: once out_valid=1, out_data is stable and out_valid stays high until out_valid&&out_ready.
  - replay_en=0 stops new reads only. A beat already held completes normally, then the stream pauses; it resumes at the next rd_ptr when replay_en returns high.
  - After the beat at index count-1 is accepted: out_valid=0 and state -> IDLE (single pass).
  - record_en and replay_start are ignored during REPLAY.
- Width rules:
  - count saturates at DEPTH; it never wraps.
  - rd_ptr and wr_ptr are ADDR_W bits; wr_ptr wraps to 0 only when count==DEPTH, and no write occurs then.
- rst mid-RECORD or mid-REPLAY: immediate return to the reset values; a held beat is dropped.

Optional Feature:
- Macro REPLAY_LOOP_EN.
- Defined: after the last beat is accepted, rd_ptr wraps to 0 and replay continues indefinitely while replay_en=1. replay_en low at a beat boundary (no beat held) returns the block to IDLE.
- Not defined: single pass as described above, and replay_en only pauses.

Decomposition:
- Shared package replay_pkg: state encoding constants (IDLE=2'd0, RECORD=2'd1, REPLAY=2'd2), DATA_W default, ADDR_W default.
- One natural sub-module: replay_mem, a simple dual-port RAM with sync read and one write port, written for iCE40 BRAM inference.
- The FSM, pointers and output register stay in replay_buffer_ctrl.

Test Plan:
1. Record "1","2","3" (0x31,0x32,0x33) with record_en=1, then drop record_en; pulse replay_start with out_ready=1, replay_en=1 -> count=3; out_data 0x31,0x32,0x33 on three consecutive cycles starting 2 cycles after the pulse; busy falls the cycle after the last beat.
2. Same recording, out_ready toggled 1,0,0,1,... -> each byte is held stable while out_ready=0, no byte is lost or duplicated, and the order is preserved.
3. ADDR_W=2, write 5 bytes 0xA0..0xA4 -> count=4, overflow=1; replay yields 0xA0..0xA3 only.
4. replay_start with count=0 -> busy stays 0 and out_valid never asserts. replay_start during RECORD -> ignored.
5. Drop replay_en after 1 of 3 beats -> the held beat completes, then no out_valid; raise replay_en -> remaining 0x32,0x33 are delivered. Assert rst mid-replay -> out_valid=0, count=0, busy=0 on the next edge.
6. With REPLAY_LOOP_EN: 2-byte record, replay for 6 beats -> 0x31,0x32,0x31,0x32,0x31,0x32; drop replay_en -> returns to IDLE.

Source files
------------

// File: rtl/replay_pkg.sv
// Shared state encoding and default widths for the record/replay byte buffer.
package replay_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    REPLAY = 2'd2
  } state_t;
endpackage

// File: rtl/replay_mem.sv
// Simple dual-port RAM, one write port and one registered read port, shaped for iCE40 BRAM inference.
module replay_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // Read data holds while re is low, so it can serve directly as the stream output register.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/replay_buffer_ctrl.sv
// Record/replay buffer controller: FSM, pointers and valid/ready replay stream.
// Build option REPLAY_LOOP_EN: replay wraps and repeats while replay_en stays high.
module replay_buffer_ctrl
  import replay_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              record_en,
  input  logic              replay_start,
  input  logic              replay_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              overflow,
  output logic [ADDR_W:0]   count
);
  localparam logic [ADDR_W:0]   FULL  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PONE  = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   rd_idx, rd_idx_nxt;
  logic [DATA_W-1:0] rd_data;
  logic              wr_fire, drop, accept, rd_issue, start_ok, last_done;

  assign accept   = out_valid && out_ready;
  assign start_ok = replay_start && (count != '0);
  assign wr_fire  = (state == RECORD) && record_en && in_valid && (count != FULL);
  assign drop     = (state == RECORD) && record_en && in_valid && (count == FULL);
  assign rd_ptr   = rd_idx[ADDR_W-1:0];

  // rd_idx counts issued reads; the extra bit tells a full buffer apart from an empty one.
`ifdef REPLAY_LOOP_EN
  assign rd_issue   = (state == REPLAY) && replay_en && (!out_valid || out_ready);
  assign rd_idx_nxt = ((rd_idx + ONE) == count) ? '0 : rd_idx + ONE;
  assign last_done  = !replay_en && !out_valid;
`else
  assign rd_issue   = (state == REPLAY) && replay_en && (!out_valid || out_ready) && (rd_idx < count);
  assign rd_idx_nxt = rd_idx + ONE;
  assign last_done  = accept && (rd_idx == count);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (record_en)     state_nxt = RECORD;
        else if (start_ok) state_nxt = REPLAY;
      end
      RECORD:  if (!record_en) state_nxt = IDLE;
      REPLAY:  if (last_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    out_data = out_valid ? rd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_idx    <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if ((state == IDLE) && record_en) begin
        count    <= '0;
        wr_ptr   <= '0;
        overflow <= 1'b0;
      end else if (wr_fire) begin
        count  <= count + ONE;
        wr_ptr <= wr_ptr + PONE;
      end
      if (drop) overflow <= 1'b1;

      if ((state == IDLE) && !record_en && start_ok) rd_idx <= '0;
      else if (rd_issue)                             rd_idx <= rd_idx_nxt;

      if (rd_issue)    out_valid <= 1'b1;
      else if (accept) out_valid <= 1'b0;
    end
  end

  replay_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr),
    .wdata (in_data),
    .re    (rd_issue),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_replay_buffer_ctrl.sv
// Self-checking bench for replay_buffer_ctrl: scoreboard of expected replay bytes, default and ADDR_W=2 instances.
module tb_replay_buffer_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       record_en, replay_start, record_en2, replay_start2;
  logic       replay_en, in_valid, out_ready;
  logic [7:0] in_data;
  logic       out_valid, busy, overflow;
  logic       out_valid2, busy2, overflow2;
  logic [7:0] out_data, out_data2;
  logic [8:0] count;
  logic [2:0] count2;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model1[$];
  logic [7:0] model2[$];
  bit         ovf1, ovf2;
  bit         mon_sel;
  bit         held;
  logic [7:0] held_data;
  logic       m_valid;
  logic [7:0] m_data;

  replay_buffer_ctrl dut (
    .clk(clk), .rst(rst), .record_en(record_en), .replay_start(replay_start),
    .replay_en(replay_en), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .overflow(overflow), .count(count)
  );

  replay_buffer_ctrl #(.DATA_W(8), .ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .record_en(record_en2), .replay_start(replay_start2),
    .replay_en(replay_en), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready),
    .busy(busy2), .overflow(overflow2), .count(count2)
  );

  assign m_valid = mon_sel ? out_valid2 : out_valid;
  assign m_data  = mon_sel ? out_data2  : out_data;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every handshake pops one expected byte; a stalled beat must stay put.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checkOutput("hold_valid", 32'(m_valid), 32'd1);
        checkOutput("hold_data", 32'(m_data), 32'(held_data));
      end
      if (m_valid && out_ready) begin
        checkOutput("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) checkOutput("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      held      = m_valid && !out_ready;
      held_data = m_data;
    end
  end

  task automatic recordBytes(input bit sel, input int n, input logic [7:0] base);
    if (sel) record_en2 = 1'b1; else record_en = 1'b1;
    tick();
    if (sel) begin model2.delete(); ovf2 = 1'b0; end
    else begin model1.delete(); ovf1 = 1'b0; end
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      tick();
      if (sel) begin
        if (model2.size() < 4) model2.push_back(in_data); else ovf2 = 1'b1;
      end else begin
        if (model1.size() < 256) model1.push_back(in_data); else ovf1 = 1'b1;
      end
    end
    in_valid   = 1'b0;
    record_en  = 1'b0;
    record_en2 = 1'b0;
    tick();
  endtask

  // Pushes the bytes the replay should produce, then pulses replay_start for one cycle.
  task automatic applyStimulus(input bit sel, input int beats);
    for (int i = 0; i < beats; i++) begin
      if (sel) exp_q.push_back(model2[i % model2.size()]);
      else     exp_q.push_back(model1[i % model1.size()]);
    end
    mon_sel = sel;
    if (sel) replay_start2 = 1'b1; else replay_start = 1'b1;
    tick();
    replay_start  = 1'b0;
    replay_start2 = 1'b0;
  endtask

  task automatic runUntilIdle(input bit sel);
    for (int c = 0; c < 60; c++) begin
      if (!(sel ? busy2 : busy)) break;
      tick();
    end
    checkOutput("idle_reached", 32'(sel ? busy2 : busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    record_en = 0; replay_start = 0; record_en2 = 0; replay_start2 = 0;
    replay_en = 0; in_valid = 0; out_ready = 0; in_data = '0; mon_sel = 0;
    tick();
    tick();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_count2", 32'(count2), 32'd0);
    rst = 1'b0;
    tick();

    // Small buffer overflow: five writes into four entries.
    recordBytes(1'b1, 5, 8'hA0);
    checkOutput("t3_count", 32'(count2), 32'(model2.size()));
    checkOutput("t3_overflow", 32'(overflow2), 32'(ovf2));
    checkOutput("t3_busy", 32'(busy2), 32'd0);

    recordBytes(1'b0, 3, 8'h31);
    checkOutput("t1_count", 32'(count), 32'(model1.size()));
    checkOutput("t1_overflow", 32'(overflow), 32'(ovf1));
    replay_en = 1'b1;
    out_ready = 1'b1;

`ifndef REPLAY_LOOP_EN
    applyStimulus(1'b0, 3);
    checkOutput("t1_busy_c1", 32'(busy), 32'd1);
    checkOutput("t1_valid_c1", 32'(out_valid), 32'd0);
    tick();
    checkOutput("t1_beat0", {23'd0, out_valid, out_data}, 32'h131);
    tick();
    checkOutput("t1_beat1", {23'd0, out_valid, out_data}, 32'h132);
    tick();
    checkOutput("t1_beat2", {23'd0, out_valid, out_data}, 32'h133);
    checkOutput("t1_busy_last", 32'(busy), 32'd1);
    tick();
    checkOutput("t1_end_valid", 32'(out_valid), 32'd0);
    checkOutput("t1_end_busy", 32'(busy), 32'd0);

    // Backpressure with out_ready pattern 1,0,0,1.
    applyStimulus(1'b0, 3);
    for (int c = 0; c < 60 && busy; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    checkOutput("t2_done", 32'(busy), 32'd0);
    checkOutput("t2_drained", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b1;

    applyStimulus(1'b1, 4);
    runUntilIdle(1'b1);
    checkOutput("t3_drained", 32'(exp_q.size()), 32'd0);
    mon_sel = 1'b0;

    // Empty buffer ignores replay_start; replay_start inside RECORD is ignored too.
    recordBytes(1'b0, 0, 8'h00);
    checkOutput("t4_count0", 32'(count), 32'd0);
    replay_start = 1'b1;
    tick();
    replay_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checkOutput("t4_no_replay", {30'd0, busy, out_valid}, 32'd0);
      tick();
    end
    record_en = 1'b1;
    tick();
    replay_start = 1'b1;
    tick();
    replay_start = 1'b0;
    checkOutput("t4_rec_no_valid", 32'(out_valid), 32'd0);
    recordBytes(1'b0, 3, 8'h31);
    checkOutput("t4_rec_count", 32'(count), 32'd3);
    checkOutput("t4_rec_busy", {30'd0, busy, out_valid}, 32'd0);

    // Pause via replay_en with a stalled beat in flight, then resume.
    applyStimulus(1'b0, 3);
    tick();
    replay_en = 1'b0;
    out_ready = 1'b0;
    tick();
    checkOutput("t5_held", {23'd0, out_valid, out_data}, 32'h131);
    out_ready = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      checkOutput("t5_paused", {30'd0, busy, out_valid}, 32'd2);
      tick();
    end
    replay_en = 1'b1;
    runUntilIdle(1'b0);
    checkOutput("t5_drained", 32'(exp_q.size()), 32'd0);

    // Reset while a beat is stalled.
    out_ready = 1'b0;
    applyStimulus(1'b0, 3);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("t5_rst", {21'd0, out_valid, busy, count}, 32'd0);
    exp_q.delete();
    model1.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
`else
    // Continuous replay of a two-byte recording for six beats.
    recordBytes(1'b0, 2, 8'h31);
    checkOutput("t6_count", 32'(count), 32'd2);
    applyStimulus(1'b0, 6);
    checkOutput("t6_busy", 32'(busy), 32'd1);
    for (int c = 0; c < 6; c++) tick();
    replay_en = 1'b0;
    runUntilIdle(1'b0);
    checkOutput("t6_valid_off", 32'(out_valid), 32'd0);
    checkOutput("t6_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("t6_count_kept", 32'(count), 32'd2);
`endif

    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
